mp_add_sequencer: RTL and testbench

//   Multi-precision adder/subtractor controller: computes W = N*K bit A+B (or A-B) by time-sharing one
//   N-bit RCAdder instance over K cycles, least-significant chunk first, carrying between chunks in a flop.

---
 rtl/mp_add_sequencer_pkg.sv | 17 +
 rtl/mp_add_sequencer_rcadder.sv | 37 +++
 rtl/mp_add_sequencer.sv | 114 +++++++++++
 tb/tb_mp_add_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/sub sequencer: state encoding
// and the chunk-index width helper.
package mp_add_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Index counter width; a single-chunk build still needs one bit.
    function automatic int idx_width(input int k);
        if (k <= 2) return 1;
        else        return $clog2(k);
    endfunction

endpackage

// File: rtl/mp_add_sequencer_rcadder.sv
// N-bit ripple-carry adder built from full-adder cells; the datapath shared
// by every chunk of a multi-precision operation.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module RCAdder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);
    logic [N:0] c;

    assign c[0] = Cin;
    assign Cout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        fullAdder u_fa (
            .a   (A[i]),
            .b   (B[i]),
            .cin (c[i]),
            .s   (S[i]),
            .cout(c[i+1])
        );
    end
endmodule

// File: rtl/mp_add_sequencer.sv
// W = N*K bit adder/subtractor that reuses one N-bit ripple adder over K cycles,
// least-significant chunk first, with valid/ready handshakes on both sides.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | in_ready=1, waiting for an operand pair
//   RUN     | one chunk per cycle, carry held in carry_q between chunks
//   DONE    | out_valid=1, result held until out_ready
module mp_add_sequencer
    import mp_add_sequencer_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] op_a,
    input  logic [N*K-1:0] op_b,
    input  logic           cin,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] sum,
    output logic           cout,
    output logic           busy
);
    localparam int W  = N * K;
    localparam int IW = idx_width(K);
    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;

    logic [N-1:0]  a_chunk;
    logic [N-1:0]  b_chunk;
    logic [N-1:0]  s_chunk;
    logic          c_chunk;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < K; k++) begin
            if (idx == IW'(k)) begin
                a_chunk = a_q[k*N +: N];
                b_chunk = b_q[k*N +: N];
            end
        end
    end

    RCAdder #(.N(N)) u_add (
        .A   (a_chunk),
        .B   (b_chunk),
        .Cin (carry_q),
        .S   (s_chunk),
        .Cout(c_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        // Subtraction is A + ~B + 1; cin is deliberately ignored.
                        b_q     <= sub ? ~op_b : op_b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx     <= '0;
                        sum_q   <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < K; k++) begin
                        if (idx == IW'(k)) sum_q[k*N +: N] <= s_chunk;
                    end
                    carry_q <= c_chunk;
                    if (idx == IDX_LAST) begin
                        cout_q <= c_chunk;
                        idx    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer (N=8, K=4): expected results are
// queued at issue time and compared when the sequencer presents out_valid.
module tb_mp_add_sequencer;
    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mp_add_sequencer #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Drive one operand pair at a negedge and return at the next negedge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input logic [W-1:0] es, input logic ec);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        op_a = a;
        op_b = b;
        cin = ci;
        sub = sb;
        in_valid = 1'b1;
        exp_q.push_back('{s: es, c: ec});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat counts negedges since the accepting edge's preceding negedge.
    task automatic collect(output int lat);
        res_t r;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("ov_timeout", out_valid, 1);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            r = exp_q.pop_front();
            chk("sum", sum, r.s);
            chk("cout", cout, r.c);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ov_drop", out_valid, 0);
        chk("ready_back", in_ready, 1);
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, (sb ? ~b : b)} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        return '{s: t[W-1:0], c: t[W]};
    endfunction

    initial begin
        int lat;
        int c;
        int na, nv;
        int acc_t[2];
        int ov_t[2];
        res_t r;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Carry out of chunk 0 into chunk 1, with latency check.
        send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        collect(lat);
        chk("latency", lat, K + 1);
        release_out();

        // Carry ripples through every chunk.
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);
        collect(lat);
        release_out();

        // Subtraction, no borrow then borrow; cin must be ignored.
        send(32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1);
        collect(lat);
        release_out();
        send(32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);
        collect(lat);
        release_out();

        // Backpressure in DONE while a new request is waiting.
        send(32'h00001234, 32'h00000001, 1'b0, 1'b0, 32'h00001235, 1'b0);
        collect(lat);
        op_a = 32'hAAAAAAAA;
        op_b = 32'h55555555;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_sum", sum, 32'h00001235);
            chk("bp_cout", cout, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_ov_drop", out_valid, 0);
        chk("bp_no_capture_sum", sum, 32'h00001235);
        @(negedge clk);
        chk("bp_no_capture_busy", busy, 0);

        // Reset asserted in RUN with idx=2 discards the partial result.
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_partial", sum, 32'h00006789);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0);
        collect(lat);
        release_out();

        // Back-to-back with out_ready tied high: accepts spaced K+2 apart.
        out_ready = 1'b1;
        op_a = 32'h80000000;
        op_b = 32'h80000000;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back('{s: 32'h00000000, c: 1'b1});
        na = 0;
        nv = 0;
        acc_t[0] = 0; acc_t[1] = 0; ov_t[0] = 0; ov_t[1] = 0;
        for (c = 0; c < 20; c++) begin
            if (c > 0 && out_valid) begin
                r = exp_q.pop_front();
                chk("b2b_sum", sum, r.s);
                chk("b2b_cout", cout, r.c);
                if (nv < 2) ov_t[nv] = c;
                nv++;
            end
            if (in_valid && in_ready) begin
                if (na < 2) acc_t[na] = c;
                na++;
                @(negedge clk);
                if (na == 1) begin
                    op_a = 32'h0000FFFF;
                    op_b = 32'h00000001;
                    exp_q.push_back('{s: 32'h00010000, c: 1'b0});
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", na, 2);
        chk("b2b_outputs", nv, 2);
        chk("b2b_acc_gap", acc_t[1] - acc_t[0], K + 2);
        chk("b2b_ov_gap", ov_t[1] - ov_t[0], K + 2);
        chk("b2b_latency", ov_t[0] - acc_t[0], K + 1);

        // A few random operations against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            r = model(ra, rb, rc, rs);
            send(ra, rb, rc, rs, r.s, r.c);
            collect(lat);
            chk("rnd_latency", lat, K + 1);
            release_out();
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
